// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode, ALU-op, write-back, class and state definitions for control_fsm
package cpu_pkg;

  localparam int OPC_W = 4;
  localparam int ALU_W = 4;

  // Opcode table, LB at 0 through TBA at 15
  localparam logic [OPC_W-1:0] OP_LB  = 4'd0;
  localparam logic [OPC_W-1:0] OP_STR = 4'd1;
  localparam logic [OPC_W-1:0] OP_ADD = 4'd2;
  localparam logic [OPC_W-1:0] OP_SUB = 4'd3;
  localparam logic [OPC_W-1:0] OP_SFT = 4'd4;
  localparam logic [OPC_W-1:0] OP_INC = 4'd5;
  localparam logic [OPC_W-1:0] OP_LIM = 4'd6;
  localparam logic [OPC_W-1:0] OP_LHB = 4'd7;
  localparam logic [OPC_W-1:0] OP_MVB = 4'd8;
  localparam logic [OPC_W-1:0] OP_MVF = 4'd9;
  localparam logic [OPC_W-1:0] OP_JMP = 4'd10;
  localparam logic [OPC_W-1:0] OP_BNE = 4'd11;
  localparam logic [OPC_W-1:0] OP_BEQ = 4'd12;
  localparam logic [OPC_W-1:0] OP_BLT = 4'd13;
  localparam logic [OPC_W-1:0] OP_HLT = 4'd14;
  localparam logic [OPC_W-1:0] OP_TBA = 4'd15;

  localparam logic [ALU_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_W-1:0] ALU_SFL = 4'd2;
  localparam logic [ALU_W-1:0] ALU_SFR = 4'd3;
  localparam logic [ALU_W-1:0] ALU_INC = 4'd4;
  localparam logic [ALU_W-1:0] ALU_DEC = 4'd5;
  localparam logic [ALU_W-1:0] ALU_BNE = 4'd6;
  localparam logic [ALU_W-1:0] ALU_BEQ = 4'd7;
  localparam logic [ALU_W-1:0] ALU_BLT = 4'd8;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_IMM = 2'd2,
    WB_REG = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  // What the sequencer does with an instruction after EXEC
  typedef enum logic [2:0] {
    CLS_REG,
    CLS_LOAD,
    CLS_STORE,
    CLS_JMP,
    CLS_BRANCH,
    CLS_ILLEGAL,
    CLS_HALT
  } instr_cls_e;

  typedef struct packed {
    logic [OPC_W-1:0] opc;
    logic             imm;
  } op_t;

endpackage

// File: rtl/op_decode.sv
// rtl/op_decode.sv - combinational opcode decode to ALU op, instruction class and write-back source
module op_decode
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opc,
  input  logic             imm,
  output logic [ALU_W-1:0] alu_inst,
  output instr_cls_e       cls,
  output wb_sel_e          wb_sel
);

  // Unlisted or unknown codes fall to the illegal class so strobes stay defined
  always_comb begin
    alu_inst = ALU_ADD;
    cls      = CLS_ILLEGAL;
    wb_sel   = WB_ALU;
    case (opc)
      OP_LB: begin
        cls    = CLS_LOAD;
        wb_sel = WB_MEM;
      end
      OP_STR: cls = CLS_STORE;
      OP_ADD: cls = CLS_REG;
      OP_SUB: begin
        cls      = CLS_REG;
        alu_inst = ALU_SUB;
      end
      OP_SFT: begin
        cls = CLS_REG;
        if (imm) alu_inst = ALU_SFR;
        else     alu_inst = ALU_SFL;
      end
      OP_INC: begin
        cls = CLS_REG;
        if (imm) alu_inst = ALU_INC;
        else     alu_inst = ALU_DEC;
      end
      OP_LIM, OP_LHB: begin
        cls    = CLS_REG;
        wb_sel = WB_IMM;
      end
      OP_MVB, OP_MVF: begin
        cls    = CLS_REG;
        wb_sel = WB_REG;
      end
      OP_JMP: cls = CLS_JMP;
      OP_BNE: begin
        cls      = CLS_BRANCH;
        alu_inst = ALU_BNE;
      end
      OP_BEQ: begin
        cls      = CLS_BRANCH;
        alu_inst = ALU_BEQ;
      end
      OP_BLT: begin
        cls      = CLS_BRANCH;
        alu_inst = ALU_BLT;
      end
      OP_HLT:  cls = CLS_HALT;
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
module control_fsm
  import cpu_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imm_flag,
  input  logic                mem_ready,
  input  logic                branch_taken,
  output logic [ALUOP_W-1:0]  alu_inst,
  output logic                alu_valid,
  output logic                ir_load,
  output logic                pc_en,
  output logic                pc_load,
  output logic                mem_read,
  output logic                mem_write,
  output logic                addr_sel,
  output logic                reg_write,
  output logic [1:0]          wb_sel,
  output logic                busy,
  output logic                halted,
  output logic                illegal_op,
  output logic                mem_err,
  output logic [CNT_W-1:0]    retired_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W:0] WAIT_LIMIT = (WAIT_W + 1)'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  op_t               op_q, op_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ill_q, ill_d;
  logic              merr_q, merr_d;

  logic [ALU_W-1:0]  dec_alu;
  instr_cls_e        dec_cls;
  wb_sel_e           dec_wb;
  logic [WAIT_W:0]   wait_nxt;
  logic              timeout;
  logic              retire;

  op_decode u_op_decode (
    .opc      (op_q.opc),
    .imm      (op_q.imm),
    .alu_inst (dec_alu),
    .cls      (dec_cls),
    .wb_sel   (dec_wb)
  );

  // Next state; the wait counter is zero unless we stay in FETCH/MEM waiting,
  // so it is cleared on every entry. A wait that would bring the counter to
  // MEM_TIMEOUT is the last one allowed; mem_ready in that cycle still wins.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    wait_d   = '0;
    cnt_d    = cnt_q;
    ill_d    = ill_q;
    merr_d   = merr_q;
    retire   = 1'b0;
    wait_nxt = {1'b0, wait_q} + (WAIT_W + 1)'(1);
    timeout  = (MEM_TIMEOUT != 0) && !mem_ready && (wait_nxt == WAIT_LIMIT);
    case (state_q)
      ST_IDLE: if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready) state_d = ST_DECODE;
        else if (timeout) begin
          merr_d  = 1'b1;
          state_d = ST_HALT;
        end else wait_d = wait_nxt[WAIT_W] ? wait_q : wait_nxt[WAIT_W-1:0];
      end
      ST_DECODE: begin
        op_d.opc = OPC_W'(opcode);
        op_d.imm = imm_flag;
        if (OPC_W'(opcode) == OP_HLT) state_d = ST_HALT;
        else                          state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (dec_cls)
          CLS_REG:             state_d = ST_WB;
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_JMP, CLS_BRANCH: retire = 1'b1;
          default: begin
            ill_d  = 1'b1;
            retire = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (dec_cls == CLS_LOAD) state_d = ST_WB;
          else                     retire = 1'b1;
        end else if (timeout) begin
          merr_d  = 1'b1;
          state_d = ST_HALT;
        end else wait_d = wait_nxt[WAIT_W] ? wait_q : wait_nxt[WAIT_W-1:0];
      end
      ST_WB:   retire = 1'b1;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    if (retire) begin
      state_d = ST_FETCH;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // Sequencer state, latched instruction, wait counter, retire count and sticky flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      merr_q  <= merr_d;
    end
  end

  // Strobes from the registered state and latched op; only the handshake
  // inputs (mem_ready, branch_taken) qualify them within a state
  always_comb begin
    alu_inst  = '0;
    alu_valid = 1'b0;
    ir_load   = 1'b0;
    pc_en     = 1'b0;
    pc_load   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr_sel  = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    case (state_q)
      ST_FETCH: begin
        mem_read = 1'b1;
        ir_load  = mem_ready;
      end
      ST_EXEC: begin
        alu_valid = 1'b1;
        alu_inst  = ALUOP_W'(dec_alu);
        wb_sel    = dec_wb;
        case (dec_cls)
          CLS_REG, CLS_LOAD, CLS_STORE: pc_en = 1'b0;
          CLS_JMP: pc_load = 1'b1;
          CLS_BRANCH: begin
            pc_load = branch_taken;
            pc_en   = !branch_taken;
          end
          default: pc_en = 1'b1;
        endcase
      end
      ST_MEM: begin
        addr_sel  = 1'b1;
        wb_sel    = dec_wb;
        mem_read  = (dec_cls == CLS_LOAD);
        mem_write = (dec_cls == CLS_STORE);
        pc_en     = (dec_cls == CLS_STORE) && mem_ready;
      end
      ST_WB: begin
        reg_write = 1'b1;
        pc_en     = 1'b1;
        wb_sel    = dec_wb;
      end
      default: wb_sel = WB_ALU;
    endcase
  end

  assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted      = (state_q == ST_HALT);
  assign illegal_op  = ill_q;
  assign mem_err     = merr_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_control_fsm.sv
// tb/tb_control_fsm.sv - vector-table and scoreboard bench for control_fsm
module tb_control_fsm;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  opcode = '0;
  logic        imm_flag = 1'b0;
  logic        mem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [3:0]  alu_inst;
  logic        alu_valid, ir_load, pc_en, pc_load, mem_read, mem_write, addr_sel, reg_write;
  logic [1:0]  wb_sel;
  logic        busy, halted, illegal_op, mem_err;
  logic [15:0] retired_cnt;

  control_fsm #(
    .OPCODE_W(4), .ALUOP_W(4), .MEM_TIMEOUT(4), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .imm_flag(imm_flag),
    .mem_ready(mem_ready), .branch_taken(branch_taken), .alu_inst(alu_inst),
    .alu_valid(alu_valid), .ir_load(ir_load), .pc_en(pc_en), .pc_load(pc_load),
    .mem_read(mem_read), .mem_write(mem_write), .addr_sel(addr_sel),
    .reg_write(reg_write), .wb_sel(wb_sel), .busy(busy), .halted(halted),
    .illegal_op(illegal_op), .mem_err(mem_err), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  // strobe bits: alu_valid ir_load pc_en pc_load mem_read mem_write addr_sel reg_write
  localparam logic [7:0] S_NONE   = 8'b0000_0000;
  localparam logic [7:0] S_FETCH  = 8'b0100_1000;
  localparam logic [7:0] S_FWAIT  = 8'b0000_1000;
  localparam logic [7:0] S_ALU    = 8'b1000_0000;
  localparam logic [7:0] S_WB     = 8'b0010_0001;
  localparam logic [7:0] S_LDM    = 8'b0000_1010;
  localparam logic [7:0] S_STM    = 8'b0000_0110;
  localparam logic [7:0] S_STDONE = 8'b0010_0110;
  localparam logic [7:0] S_JMP    = 8'b1001_0000;
  localparam logic [7:0] S_BNT    = 8'b1010_0000;
  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_BUSY = 2'd1;
  localparam logic [1:0] M_HALT = 2'd2;

  typedef struct {
    logic        st;
    logic [3:0]  opc;
    logic        imm;
    logic        rdy;
    logic        bt;
    logic [3:0]  alu;
    logic [7:0]  strb;
    logic [1:0]  wb;
    logic [3:0]  fl;
    logic [15:0] cnt;
  } vec_t;

  vec_t        tbl[$];
  vec_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          vidx = 0;
  logic [15:0] ecnt = '0;
  logic        eill = 1'b0;
  logic        emerr = 1'b0;

  function automatic vec_t mk(logic st, logic [3:0] opc, logic imm, logic rdy, logic bt,
                              logic [3:0] alu, logic [7:0] strb, logic [1:0] wb, logic [1:0] mode);
    vec_t v;
    v.st = st; v.opc = opc; v.imm = imm; v.rdy = rdy; v.bt = bt;
    v.alu = alu; v.strb = strb; v.wb = wb;
    v.fl = {mode == M_BUSY, mode == M_HALT, eill, emerr};
    v.cnt = ecnt;
    return v;
  endfunction

  task automatic t(logic st, logic [3:0] opc, logic imm, logic rdy, logic bt,
                   logic [3:0] alu, logic [7:0] strb, logic [1:0] wb, logic [1:0] mode);
    tbl.push_back(mk(st, opc, imm, rdy, bt, alu, strb, wb, mode));
  endtask

  task automatic check(string name);
    vec_t        e;
    logic [33:0] a, x;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    a = {alu_inst, alu_valid, ir_load, pc_en, pc_load, mem_read, mem_write, addr_sel,
         reg_write, wb_sel, busy, halted, illegal_op, mem_err, retired_cnt};
    x = {e.alu, e.strb, e.wb, e.fl, e.cnt};
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s #%0d: got alu=%h strb=%b wb=%0d flags=%b cnt=%0d, want alu=%h strb=%b wb=%0d flags=%b cnt=%0d",
               name, vidx, a[33:30], a[29:22], a[21:20], a[19:16], a[15:0],
               x[33:30], x[29:22], x[21:20], x[19:16], x[15:0]);
    end
  endtask

  task automatic apply(vec_t v, string name);
    @(posedge clk);
    #1;
    start = v.st; opcode = v.opc; imm_flag = v.imm; mem_ready = v.rdy; branch_taken = v.bt;
    sb.push_back(v);
    @(negedge clk);
    check(name);
    vidx++;
  endtask

  task automatic run_tbl(string name);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], name);
    tbl.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; opcode = '0; imm_flag = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
    ecnt = '0; eill = 1'b0; emerr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sb.push_back(mk(0, 0, 0, 0, 0, 0, S_NONE, 0, M_IDLE));
    check("reset");
    reset = 1'b0;
  endtask

  // Instruction builders: each appends the per-cycle vectors of one instruction.
  // EXEC drives a different opcode/imm on the inputs to show the latched copy is used.
  task automatic i_fetch();
    t(0, 0, 0, 1, 0, 0, S_FETCH, 0, M_BUSY);
  endtask

  task automatic i_dec(logic [3:0] opc, logic imm);
    i_fetch();
    t(0, opc, imm, 0, 0, 0, S_NONE, 0, M_BUSY);
  endtask

  task automatic i_reg(logic [3:0] opc, logic imm, logic [3:0] alu, logic [1:0] wb);
    i_dec(opc, imm);
    t(0, ~opc, !imm, 0, 0, alu, S_ALU, wb, M_BUSY);
    t(0, 0, !imm, 0, 0, 0, S_WB, wb, M_BUSY);
    ecnt++;
  endtask

  task automatic i_br(logic [3:0] opc, logic [3:0] alu, logic bt);
    i_dec(opc, 0);
    t(0, ~opc, 0, 0, bt, alu, bt ? S_JMP : S_BNT, 0, M_BUSY);
    ecnt++;
  endtask

  task automatic i_ld(int waits);
    i_dec(OP_LB, 0);
    t(0, 0, 0, 0, 0, ALU_ADD, S_ALU, WB_MEM, M_BUSY);
    repeat (waits) t(0, 0, 0, 0, 0, 0, S_LDM, WB_MEM, M_BUSY);
    t(0, 0, 0, 1, 0, 0, S_LDM, WB_MEM, M_BUSY);
    t(0, 0, 0, 0, 0, 0, S_WB, WB_MEM, M_BUSY);
    ecnt++;
  endtask

  task automatic i_st(int waits);
    i_dec(OP_STR, 0);
    t(0, 0, 0, 0, 0, ALU_ADD, S_ALU, WB_ALU, M_BUSY);
    repeat (waits) t(0, 0, 0, 0, 0, 0, S_STM, 0, M_BUSY);
    t(0, 0, 0, 1, 0, 0, S_STDONE, 0, M_BUSY);
    ecnt++;
  endtask

  task automatic i_tba();
    i_dec(OP_TBA, 0);
    t(0, 0, 0, 0, 0, ALU_ADD, S_BNT, 0, M_BUSY);
    ecnt++;
    eill = 1'b1;
  endtask

  initial begin
    // Main table: one of every instruction kind
    do_reset();
    t(1, 0, 0, 0, 0, 0, S_NONE, 0, M_IDLE);
    i_reg(OP_ADD, 0, ALU_ADD, WB_ALU);
    i_ld(3);
    i_br(OP_BEQ, ALU_BEQ, 1);
    i_br(OP_BEQ, ALU_BEQ, 0);
    i_reg(OP_SFT, 1, ALU_SFR, WB_ALU);
    i_reg(OP_SFT, 0, ALU_SFL, WB_ALU);
    i_reg(OP_INC, 1, ALU_INC, WB_ALU);
    i_reg(OP_INC, 0, ALU_DEC, WB_ALU);
    i_reg(OP_SUB, 0, ALU_SUB, WB_ALU);
    i_reg(OP_LIM, 0, ALU_ADD, WB_IMM);
    i_reg(OP_LHB, 1, ALU_ADD, WB_IMM);
    i_reg(OP_MVB, 0, ALU_ADD, WB_REG);
    i_reg(OP_MVF, 1, ALU_ADD, WB_REG);
    repeat (2) t(0, 0, 0, 0, 0, 0, S_FWAIT, 0, M_BUSY);
    i_st(1);
    i_br(OP_JMP, ALU_ADD, 0);
    tbl[tbl.size() - 1].strb = S_JMP;
    i_br(OP_BNE, ALU_BNE, 1);
    i_br(OP_BLT, ALU_BLT, 0);
    i_tba();
    i_reg(OP_ADD, 0, ALU_ADD, WB_ALU);
    i_fetch();
    run_tbl("main");

    // Memory wait boundary: ready on the last allowed wait succeeds, then a store times out
    do_reset();
    t(1, 0, 0, 0, 0, 0, S_NONE, 0, M_IDLE);
    i_st(3);
    i_dec(OP_STR, 0);
    t(0, 0, 0, 0, 0, ALU_ADD, S_ALU, 0, M_BUSY);
    repeat (4) t(0, 0, 0, 0, 0, 0, S_STM, 0, M_BUSY);
    emerr = 1'b1;
    repeat (3) t(1, 0, 0, 1, 0, 0, S_NONE, 0, M_HALT);
    run_tbl("timeout");

    // Illegal opcode retires as a NOP, then HALT stops the machine for good
    do_reset();
    t(1, 0, 0, 0, 0, 0, S_NONE, 0, M_IDLE);
    i_tba();
    i_dec(OP_HLT, 0);
    repeat (3) t(1, 0, 0, 1, 0, 0, S_NONE, 0, M_HALT);
    run_tbl("halt");

    // Reset in the middle of a load: everything drops at once and nothing retires
    do_reset();
    t(1, 0, 0, 0, 0, 0, S_NONE, 0, M_IDLE);
    i_reg(OP_ADD, 0, ALU_ADD, WB_ALU);
    i_dec(OP_LB, 0);
    t(0, 0, 0, 0, 0, ALU_ADD, S_ALU, WB_MEM, M_BUSY);
    t(0, 0, 0, 0, 0, 0, S_LDM, WB_MEM, M_BUSY);
    run_tbl("pre_reset");
    #1;
    mem_ready = 1'b1;
    reset = 1'b1;
    ecnt = '0;
    #1;
    sb.push_back(mk(0, 0, 0, 1, 0, 0, S_NONE, 0, M_IDLE));
    check("reset_mid_mem");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) t(0, OP_ADD, 0, 1, 0, 0, S_NONE, 0, M_IDLE);
    t(1, 0, 0, 0, 0, 0, S_NONE, 0, M_IDLE);
    i_fetch();
    run_tbl("post_reset");

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
